// File: rtl/bpu_update_ctrl.sv
// BPU update scheduler: two valid/ready requesters feed an in-order FIFO; one update/cycle out, no output backpressure.
// Latency 1 cycle (0 with BPU_UPD_BYPASS_EN); readies follow free slots at cycle start, low on flush/reset.
package mmm_pkg;
  localparam int XLEN = 32;
  localparam int HLEN = 8;
endpackage

module bpu_update_ctrl
  import mmm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [XLEN-1:0] req0_pc_i,
  input  logic [HLEN-1:0] req0_index_i,
  input  logic [XLEN-1:0] req0_target_i,
  input  logic            req0_taken_i,
  input  logic            req0_mispredict_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [XLEN-1:0] req1_pc_i,
  input  logic [HLEN-1:0] req1_index_i,
  input  logic [XLEN-1:0] req1_target_i,
  input  logic            req1_taken_i,
  input  logic            req1_mispredict_i,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_pc_o,
  output logic [HLEN-1:0] res_index_o,
  output logic [XLEN-1:0] res_target_o,
  output logic            res_taken_o,
  output logic            res_mispredict_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } upd_t;

  upd_t          mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, free;
  logic          prio;
  upd_t          req0_dat, req1_dat, head_dat, res_dat, res_out, wr_a_dat, wr_b_dat;
  logic          sel1, acc0, acc1, pop, byp_vld, wr_a_vld, wr_b_vld;
  logic [1:0]    n_wr;

  assign req0_dat = '{pc: req0_pc_i, index: req0_index_i, target: req0_target_i,
                      taken: req0_taken_i, mispredict: req0_mispredict_i};
  assign req1_dat = '{pc: req1_pc_i, index: req1_index_i, target: req1_target_i,
                      taken: req1_taken_i, mispredict: req1_mispredict_i};
  assign free     = CW'(DEPTH) - count;
  assign head_dat = mem[rptr];

  // With one slot left, prio picks the winner unless it is idle, then the other side gets it.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    sel1         = prio ? req1_valid_i : ~req0_valid_i;
    if (!rst_i && !flush_i && free != '0) begin
      if (free == CW'(1)) begin
        req0_ready_o = ~sel1;
        req1_ready_o = sel1;
      end else begin
        req0_ready_o = 1'b1;
        req1_ready_o = 1'b1;
      end
    end
  end

  assign acc0 = req0_valid_i & req0_ready_o;
  assign acc1 = req1_valid_i & req1_ready_o;

`ifdef BPU_UPD_BYPASS_EN
  // Acceptance is already blocked by flush, so an empty queue plus any accept means bypass.
  assign byp_vld = (count == '0) & (acc0 | acc1);
`else
  assign byp_vld = 1'b0;
`endif

  always_comb begin
    wr_a_vld = 1'b0;
    wr_b_vld = 1'b0;
    wr_a_dat = req0_dat;
    wr_b_dat = req1_dat;
    res_dat  = head_dat;
    if (byp_vld) begin
      res_dat  = acc0 ? req0_dat : req1_dat;
      wr_a_vld = acc0 & acc1;
      wr_a_dat = req1_dat;
    end else begin
      wr_a_vld = acc0 | acc1;
      wr_a_dat = acc0 ? req0_dat : req1_dat;
      wr_b_vld = acc0 & acc1;
    end
  end

  assign n_wr        = {1'b0, wr_a_vld} + {1'b0, wr_b_vld};
  assign res_valid_o = ((count != '0) | byp_vld) & ~flush_i & ~rst_i;
  assign pop         = res_valid_o & (count != '0);

  assign res_out          = res_valid_o ? res_dat : '0;
  assign res_pc_o         = res_out.pc;
  assign res_index_o      = res_out.index;
  assign res_target_o     = res_out.target;
  assign res_taken_o      = res_out.taken;
  assign res_mispredict_o = res_out.mispredict;
  assign occupancy_o      = count;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      count <= count + CW'(n_wr) - CW'(pop);
      wptr  <= wptr + AW'(n_wr);
      if (pop) rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio <= 1'b0;
    end else if (!flush_i && free == CW'(1) && req0_valid_i && req1_valid_i) begin
      prio <= ~prio;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_a_vld) mem[wptr] <= wr_a_dat;
    if (wr_b_vld) mem[wptr + AW'(1)] <= wr_b_dat;
  end
endmodule
